strided_addr_counter: RTL and testbench

STRIDED_ADDR_COUNTER -- requirements
Module: strided_addr_counter

---
 rtl/strided_cnt_pkg.sv | 11 +
 rtl/strided_next_calc.sv | 48 ++++
 rtl/strided_addr_counter.sv | 65 ++++++
 tb/tb_strided_addr_counter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/strided_cnt_pkg.sv
// Shared definitions for the strided address counter: step-mode encodings.
package strided_cnt_pkg;

    typedef enum logic [1:0] {
        MODE_LINEAR = 2'd0,
        MODE_ODD    = 2'd1,
        MODE_EVEN   = 2'd2,
        MODE_CUSTOM = 2'd3
    } mode_e;

endpackage

// File: rtl/strided_next_calc.sv
// Combinational next-value and overflow computation for the strided address counter.
module strided_next_calc
    import strided_cnt_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int STEP_W = 4
) (
    input  logic [WIDTH-1:0]  count,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    output logic [WIDTH-1:0]  next,
    output logic              over
);

    localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] TWO = (WIDTH+1)'(2);

    // One extra bit so the sum cannot alias back under the limit.
    logic [WIDTH:0] count_x;
    logic [WIDTH:0] step_x;
    logic [WIDTH:0] limit_x;
    logic [WIDTH:0] next_full;

    assign count_x = {1'b0, count};
    assign step_x  = {{(WIDTH+1-STEP_W){1'b0}}, step};
    assign limit_x = {1'b0, limit};

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        next_full = count_x;
        over      = 1'b0;
        case (mode)
            MODE_LINEAR: next_full = count_x + ONE;
            MODE_ODD:    next_full = (count == '0) ? ONE : count_x + TWO;
            MODE_EVEN:   next_full = count_x + TWO;
            MODE_CUSTOM: next_full = count_x + step_x;
        endcase
        over = next_full > limit_x;
        // A zero custom stride is a hold, never an overflow, even above the limit.
        if (mode == MODE_CUSTOM && step == '0) begin
            over = 1'b0;
        end
    end

    assign next = next_full[WIDTH-1:0];

endmodule

// File: rtl/strided_addr_counter.sv
// Strided address counter with linear/odd/even/custom stepping and wrap pulse.
// Define STRIDED_CNT_SAT_EN to saturate (hold count, assert wrap) instead of wrapping to 0.
module strided_addr_counter
    import strided_cnt_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    output logic [WIDTH-1:0]  count,
    output logic              wrap
);

    logic [WIDTH-1:0] next;
    logic             over;

    strided_next_calc #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_next_calc (
        .count (count),
        .mode  (mode),
        .step  (step),
        .limit (limit),
        .next  (next),
        .over  (over)
    );

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (clear) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= load_val;
            wrap  <= 1'b0;
        end else if (enable) begin
            if (over) begin
`ifdef STRIDED_CNT_SAT_EN
                count <= count;
`else
                count <= '0;
`endif
                wrap  <= 1'b1;
            end else begin
                count <= next;
                wrap  <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_strided_addr_counter.sv
// Self-checking bench for strided_addr_counter: directed table, odd-mode sweep, random vs model.
module tb_strided_addr_counter;
    import strided_cnt_pkg::*;

`ifdef STRIDED_CNT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, enable, clear, load;
    logic [9:0] load_val, limit;
    logic [1:0] mode;
    logic [3:0] step;
    logic [9:0] count;
    logic       wrap;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    strided_addr_counter #(.WIDTH(10), .STEP_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .mode     (mode),
        .step     (step),
        .limit    (limit),
        .count    (count),
        .wrap     (wrap)
    );

    typedef struct {
        logic       reset, clear, load, enable;
        logic [1:0] mode;
        logic [3:0] step;
        logic [9:0] limit;
        logic [9:0] load_val;
        int         exp_count;
        int         exp_wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic c, input logic l, input logic e,
                                input logic [1:0] m, input logic [3:0] s, input logic [9:0] lim,
                                input logic [9:0] lv, input int ec, input int ew);
        vec_t v;
        v.reset = r; v.clear = c; v.load = l; v.enable = e;
        v.mode = m; v.step = s; v.limit = lim; v.load_val = lv;
        v.exp_count = ec; v.exp_wrap = ew;
        return v;
    endfunction

    task automatic drive(input logic r, input logic c, input logic l, input logic e,
                         input logic [1:0] m, input logic [3:0] s, input logic [9:0] lim,
                         input logic [9:0] lv);
        reset = r; clear = c; load = l; enable = e;
        mode = m; step = s; limit = lim; load_val = lv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state, updated from the plain arithmetic rules of each operation.
    int m_count, m_wrap;

    task automatic model_update();
        int n;
        if (reset || clear) begin
            m_count = 0; m_wrap = 0;
        end else if (load) begin
            m_count = int'(load_val); m_wrap = 0;
        end else if (enable) begin
            if (mode == 2'd0)      n = m_count + 1;
            else if (mode == 2'd1) n = (m_count == 0) ? 1 : m_count + 2;
            else if (mode == 2'd2) n = m_count + 2;
            else                   n = m_count + int'(step);
            if (mode == 2'd3 && step == 4'd0) begin
                m_wrap = 0;
            end else if (n > int'(limit)) begin
                if (!SAT) m_count = 0;
                m_wrap = 1;
            end else begin
                m_count = n; m_wrap = 0;
            end
        end else begin
            m_wrap = 0;
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, MODE_LINEAR, 4'd0, 10'd5, 10'd0);

        // Directed vectors, applied in order: each row's expectation follows from the previous rows.
        vecs.push_back(mk(1, 0, 0, 1, MODE_LINEAR, 0, 5,   0,  0, 0));
        vecs.push_back(mk(0, 0, 0, 1, MODE_LINEAR, 0, 5,   0,  1, 0));
        vecs.push_back(mk(0, 0, 0, 1, MODE_LINEAR, 0, 5,   0,  2, 0));
        vecs.push_back(mk(0, 0, 0, 1, MODE_LINEAR, 0, 5,   0,  3, 0));
        vecs.push_back(mk(0, 1, 0, 1, MODE_LINEAR, 0, 5,   0,  0, 0));
        vecs.push_back(mk(0, 0, 0, 1, MODE_LINEAR, 0, 5,   0,  1, 0));
        vecs.push_back(mk(0, 0, 0, 1, MODE_LINEAR, 0, 5,   0,  2, 0));
        vecs.push_back(mk(0, 0, 0, 1, MODE_LINEAR, 0, 5,   0,  3, 0));
        vecs.push_back(mk(0, 0, 0, 1, MODE_LINEAR, 0, 5,   0,  4, 0));
        vecs.push_back(mk(0, 0, 0, 1, MODE_LINEAR, 0, 5,   0,  5, 0));
        vecs.push_back(mk(0, 0, 0, 1, MODE_LINEAR, 0, 5,   0, SAT ? 5 : 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, MODE_LINEAR, 0, 5,   0, SAT ? 5 : 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, MODE_CUSTOM, 3, 10,  0,  0, 0));
        vecs.push_back(mk(0, 0, 0, 1, MODE_CUSTOM, 3, 10,  0,  3, 0));
        vecs.push_back(mk(0, 0, 0, 1, MODE_CUSTOM, 3, 10,  0,  6, 0));
        vecs.push_back(mk(0, 0, 0, 1, MODE_CUSTOM, 3, 10,  0,  9, 0));
        vecs.push_back(mk(0, 0, 0, 1, MODE_CUSTOM, 3, 10,  0, SAT ? 9 : 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, MODE_CUSTOM, 0, 10,  0,  0, 0));
        vecs.push_back(mk(0, 0, 0, 1, MODE_CUSTOM, 0, 10,  0,  0, 0));
        vecs.push_back(mk(0, 0, 0, 1, MODE_CUSTOM, 0, 10,  0,  0, 0));
        vecs.push_back(mk(0, 0, 1, 1, MODE_LINEAR, 0, 100, 200, 200, 0));
        vecs.push_back(mk(0, 0, 0, 1, MODE_LINEAR, 0, 100, 0, SAT ? 200 : 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, MODE_CUSTOM, 0, 100, 0, SAT ? 200 : 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, MODE_EVEN,   0, 1023, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, MODE_EVEN,   0, 1023, 0, 2, 0));
        vecs.push_back(mk(0, 0, 0, 1, MODE_EVEN,   0, 1023, 0, 4, 0));
        vecs.push_back(mk(0, 0, 0, 1, MODE_ODD,    0, 1023, 0, 6, 0));
        vecs.push_back(mk(0, 0, 0, 1, MODE_ODD,    0, 1023, 0, 8, 0));
        vecs.push_back(mk(1, 0, 1, 1, MODE_ODD,    0, 1023, 77, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, MODE_EVEN,   0, 1023, 0, 2, 0));
        vecs.push_back(mk(0, 0, 0, 1, MODE_EVEN,   0, 6,    0, 4, 0));
        vecs.push_back(mk(0, 0, 0, 1, MODE_EVEN,   0, 6,    0, 6, 0));
        vecs.push_back(mk(0, 0, 0, 1, MODE_EVEN,   0, 6,    0, SAT ? 6 : 0, 1));

        foreach (vecs[i]) begin
            drive(vecs[i].reset, vecs[i].clear, vecs[i].load, vecs[i].enable,
                  vecs[i].mode, vecs[i].step, vecs[i].limit, vecs[i].load_val);
            tick();
            check($sformatf("vec%0d count", i), int'(count), vecs[i].exp_count);
            check($sformatf("vec%0d wrap", i), int'(wrap), vecs[i].exp_wrap);
        end

        // Odd-mode sweep from reset across the full 10-bit range.
        drive(1'b1, 1'b0, 1'b0, 1'b1, MODE_ODD, 4'd0, 10'd1023, 10'd0);
        tick();
        check("odd reset count", int'(count), 0);
        reset = 1'b0;
        for (int k = 1; k <= 514; k++) begin
            int ec, ew;
            tick();
            if (k <= 512)      begin ec = 2 * k - 1;          ew = 0;       end
            else if (k == 513) begin ec = SAT ? 1023 : 0;     ew = 1;       end
            else               begin ec = SAT ? 1023 : 1;     ew = int'(SAT); end
            check($sformatf("odd k%0d count", k), int'(count), ec);
            check($sformatf("odd k%0d wrap", k), int'(wrap), ew);
        end

        // Randomized stimulus against the reference model.
        drive(1'b1, 1'b0, 1'b0, 1'b0, MODE_LINEAR, 4'd0, 10'd0, 10'd0);
        model_update();
        tick();
        check("rand reset count", int'(count), m_count);
        for (int i = 0; i < 3000; i++) begin
            logic [9:0] lim;
            lim = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 40));
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                  2'($urandom), 4'($urandom), lim,
                  ($urandom_range(0, 1) == 0) ? 10'($urandom) : 10'($urandom_range(0, 40)));
            model_update();
            tick();
            check($sformatf("rand%0d count", i), int'(count), m_count);
            check($sformatf("rand%0d wrap", i), int'(wrap), m_wrap);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
